saida_bcd_sequencial: RTL and testbench

- Output-side counterpart of the switch-entry handshake. The core hands a word over with a one-cycle strobe, and the block stalls the core until the word is shown.
- Converts a DATA_WIDTH binary word to DIGITS BCD digits with an iterative shift-add-3 (double dabble), one bit per clock.
- Registers the digits and drives active-low 7-segment patterns for the display bank.
- Exposes ocupado (busy), which the control unit ORs into its halt so the PC freezes during conversion.

---
 rtl/saida_bcd_sequencial_if.sv | 24 ++
 rtl/saida_bcd_sequencial.sv | 139 +++++++++++++
 tb/tb_saida_bcd_sequencial.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/saida_bcd_sequencial_if.sv
// Display-side handshake bundle between the core (master) and the BCD output block (slave).
// Carries the word/strobe request, the busy/done status and the registered display outputs.
interface saida_bcd_sequencial_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
);
  logic [DATA_WIDTH-1:0] dado;
  logic                  atualiza;
  logic                  ocupado;
  logic                  pronto;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;
  logic                  sinal;

  modport master (
    output dado, atualiza,
    input  ocupado, pronto, bcd, seg, sinal
  );

  modport slave (
    input  dado, atualiza,
    output ocupado, pronto, bcd, seg, sinal
  );
endinterface

// File: rtl/saida_bcd_sequencial.sv
// Sequential binary-to-BCD output stage: double dabble one bit per clock, then registered BCD and 7-segment.
// Optional macro SAIDA_SINAL_EN treats dado as two's complement and shows the sign on sinal.
module saida_bcd_sequencial #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                  read_clock,
  input  logic                  reset,
  saida_bcd_sequencial_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [DATA_WIDTH-1:0] shift;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adjusted;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] magnitude;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic [7*DIGITS-1:0]   seg_reg;
  logic [7*DIGITS-1:0]   seg_next;
  logic                  ocupado_reg;
  logic                  pronto_reg;

  function automatic logic [6:0] decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) state <= OCIOSO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      OCIOSO:   if (bus.atualiza) next_state = CONVERTE;
      CONVERTE: if (count == CW'(1)) next_state = ATUALIZA;
      ATUALIZA: next_state = OCIOSO;
      default:  next_state = OCIOSO;
    endcase
  end

  // Add-3 is done per nibble with no carry across digits; the width rule keeps each nibble <= 12.
  always_comb begin
    adjusted = scratch;
    seg_next = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      seg_next[7*i +: 7] = decode(scratch[4*i +: 4]);
    end
  end

`ifdef SAIDA_SINAL_EN
  logic sign_latched;
  logic sinal_reg;

  always_comb begin
    magnitude = bus.dado;
    if (bus.dado[DATA_WIDTH-1]) magnitude = ~bus.dado + DATA_WIDTH'(1);
  end

  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      sign_latched <= 1'b0;
      sinal_reg    <= 1'b0;
    end else begin
      if (state == OCIOSO && bus.atualiza) sign_latched <= bus.dado[DATA_WIDTH-1];
      if (state == ATUALIZA)               sinal_reg    <= sign_latched;
    end
  end

  assign bus.sinal = sinal_reg;
`else
  assign magnitude = bus.dado;
  assign bus.sinal = 1'b0;
`endif

  // Display registers only change in ATUALIZA, so the old value stays visible during conversion.
  always_ff @(posedge read_clock or negedge reset) begin
    if (!reset) begin
      shift       <= '0;
      scratch     <= '0;
      count       <= '0;
      bcd_reg     <= '0;
      seg_reg     <= {DIGITS{7'b0000001}};
      ocupado_reg <= 1'b0;
      pronto_reg  <= 1'b0;
    end else begin
      ocupado_reg <= (next_state != OCIOSO);
      pronto_reg  <= (state == ATUALIZA);
      case (state)
        OCIOSO: begin
          if (bus.atualiza) begin
            shift   <= magnitude;
            scratch <= '0;
            count   <= CW'(DATA_WIDTH);
          end
        end
        CONVERTE: begin
          scratch <= {adjusted[4*DIGITS-2:0], shift[DATA_WIDTH-1]};
          shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
          count   <= count - CW'(1);
        end
        ATUALIZA: begin
          bcd_reg <= scratch;
          seg_reg <= seg_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.ocupado = ocupado_reg;
  assign bus.pronto  = pronto_reg;
  assign bus.bcd     = bcd_reg;
  assign bus.seg     = seg_reg;

endmodule

// File: tb/tb_saida_bcd_sequencial.sv
// Directed bench for saida_bcd_sequencial: latency, busy handling, reset abort and sign build.
// Inputs change and outputs are sampled on the falling edge, away from the active rising edge.
module tb_saida_bcd_sequencial;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  localparam logic [34:0] SEG_ZERO = {5{7'b0000001}};

  saida_bcd_sequencial_if #(.DATA_WIDTH(16), .DIGITS(5)) bus_if ();

  saida_bcd_sequencial #(.DATA_WIDTH(16), .DIGITS(5)) dut (
    .read_clock (clk),
    .reset      (rst_n),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic strobe(input logic [15:0] value);
    @(negedge clk);
    bus_if.dado     = value;
    bus_if.atualiza = 1'b1;
    @(negedge clk);
    bus_if.atualiza = 1'b0;
  endtask

  // Samples one falling edge per iteration; i counts rising edges since the accepted strobe.
  task automatic observe(input int window, input int inject_edge, input logic [15:0] inject_val,
                         output int busy_cycles, output int pronto_count, output int last_pronto,
                         output logic [19:0] mid_bcd);
    busy_cycles  = 0;
    pronto_count = 0;
    last_pronto  = -1;
    mid_bcd      = 'x;
    for (int i = 0; i < window; i++) begin
      if (bus_if.ocupado === 1'b1) busy_cycles++;
      if (bus_if.pronto === 1'b1) begin
        pronto_count++;
        last_pronto = i;
      end
      if (i == 8) mid_bcd = bus_if.bcd;
      if (i == inject_edge) begin
        bus_if.dado     = inject_val;
        bus_if.atualiza = 1'b1;
      end else begin
        bus_if.atualiza = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.atualiza = 1'b0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus_if.dado     = '0;
    bus_if.atualiza = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus_if.ocupado !== 1'b0 || bus_if.pronto !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: ocupado=%b pronto=%b, required 0 0", bus_if.ocupado, bus_if.pronto);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.bcd !== 20'h00000) begin
      tests_failed++;
      $display("[TB] FAIL reset_bcd: got %h, required 00000", bus_if.bcd);
    end
    tests_run++;
    if (bus_if.seg !== SEG_ZERO) begin
      tests_failed++;
      $display("[TB] FAIL reset_seg: got %b, required %b", bus_if.seg, SEG_ZERO);
    end
    tests_run++;
    if (bus_if.ocupado !== 1'b0 || bus_if.pronto !== 1'b0 || bus_if.sinal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: ocupado=%b pronto=%b sinal=%b, required 0 0 0",
               bus_if.ocupado, bus_if.pronto, bus_if.sinal);
    end
  endtask

  task automatic test_value_12345();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'd12345);
    observe(22, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (busy != 17) begin
      tests_failed++;
      $display("[TB] FAIL busy_cycles_12345: got %0d, required 17", busy);
    end
    tests_run++;
    if (npr != 1 || lastp != 17) begin
      tests_failed++;
      $display("[TB] FAIL pronto_12345: count %0d at edge %0d, required 1 at 17", npr, lastp);
    end
    tests_run++;
    if (mid !== 20'h00000) begin
      tests_failed++;
      $display("[TB] FAIL hold_during_conv: got %h, required 00000", mid);
    end
    tests_run++;
    if (bus_if.bcd !== 20'h12345) begin
      tests_failed++;
      $display("[TB] FAIL bcd_12345: got %h, required 12345", bus_if.bcd);
    end
    tests_run++;
    if (bus_if.seg !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100}) begin
      tests_failed++;
      $display("[TB] FAIL seg_12345: got %b, required 1001111 0010010 0000110 1001100 0100100", bus_if.seg);
    end
  endtask

  task automatic test_max_and_zero();
    int busy, npr, lastp;
    logic [19:0] mid;
    logic [19:0] exp_max;
`ifdef SAIDA_SINAL_EN
    exp_max = 20'h00001;
`else
    exp_max = 20'h65535;
`endif
    strobe(16'd65535);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.bcd !== exp_max || npr != 1) begin
      tests_failed++;
      $display("[TB] FAIL bcd_max: got %h pronto %0d, required %h pronto 1", bus_if.bcd, npr, exp_max);
    end
`ifndef SAIDA_SINAL_EN
    tests_run++;
    if (bus_if.seg !== {7'b0100000, 7'b0100100, 7'b0100100, 7'b0000110, 7'b0100100}) begin
      tests_failed++;
      $display("[TB] FAIL seg_max: got %b, required 0100000 0100100 0100100 0000110 0100100", bus_if.seg);
    end
`endif
    strobe(16'd0);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.bcd !== 20'h00000 || bus_if.seg !== SEG_ZERO || npr != 1 || lastp != 17) begin
      tests_failed++;
      $display("[TB] FAIL bcd_zero: got %h seg %b pronto %0d@%0d, required 00000 all-zero 1@17",
               bus_if.bcd, bus_if.seg, npr, lastp);
    end
  endtask

  task automatic test_request_while_busy();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'd12345);
    observe(40, 5, 16'd999, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.bcd !== 20'h12345 || npr != 1) begin
      tests_failed++;
      $display("[TB] FAIL busy_drop: got %h pronto %0d, required 12345 pronto 1", bus_if.bcd, npr);
    end
  endtask

  task automatic test_drop_in_atualiza();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'd4321);
    observe(40, 16, 16'd999, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.bcd !== 20'h04321 || npr != 1 || busy != 17) begin
      tests_failed++;
      $display("[TB] FAIL atualiza_drop: got %h pronto %0d busy %0d, required 04321 1 17",
               bus_if.bcd, npr, busy);
    end
    tests_run++;
    if (mid !== 20'h12345) begin
      tests_failed++;
      $display("[TB] FAIL hold_previous: got %h, required 12345", mid);
    end
  endtask

  task automatic test_back_to_back();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'd12345);
    observe(40, 17, 16'd999, busy, npr, lastp, mid);
    tests_run++;
    if (npr != 2 || lastp != 35) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_pronto: count %0d last edge %0d, required 2 at 35", npr, lastp);
    end
    tests_run++;
    if (bus_if.bcd !== 20'h00999 || bus_if.seg !== {7'b0000001, 7'b0000001, {3{7'b0000100}}}) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_value: got %h seg %b, required 00999", bus_if.bcd, bus_if.seg);
    end
  endtask

  task automatic test_reset_mid();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'd54321);
    observe(8, -1, 16'd0, busy, npr, lastp, mid);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.ocupado !== 1'b0 || bus_if.pronto !== 1'b0 || bus_if.bcd !== 20'h00000 ||
        bus_if.seg !== SEG_ZERO || bus_if.sinal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_abort: ocupado=%b pronto=%b bcd=%h sinal=%b, required 0 0 00000 0",
               bus_if.ocupado, bus_if.pronto, bus_if.bcd, bus_if.sinal);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (npr != 0 || busy != 0 || bus_if.bcd !== 20'h00000) begin
      tests_failed++;
      $display("[TB] FAIL abort_not_shown: pronto %0d busy %0d bcd %h, required 0 0 00000", npr, busy, bus_if.bcd);
    end
    strobe(16'd777);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.bcd !== 20'h00777 || npr != 1 || lastp != 17 || busy != 17) begin
      tests_failed++;
      $display("[TB] FAIL after_abort_777: got %h pronto %0d@%0d busy %0d, required 00777 1@17 17",
               bus_if.bcd, npr, lastp, busy);
    end
    tests_run++;
    if (bus_if.seg !== {7'b0000001, 7'b0000001, {3{7'b0001111}}}) begin
      tests_failed++;
      $display("[TB] FAIL seg_777: got %b, required 0000001 0000001 0001111 x3", bus_if.seg);
    end
  endtask

  task automatic test_sign();
    int busy, npr, lastp;
    logic [19:0] mid;
    strobe(16'hFFFF);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
`ifdef SAIDA_SINAL_EN
    tests_run++;
    if (bus_if.sinal !== 1'b1 || bus_if.bcd !== 20'h00001) begin
      tests_failed++;
      $display("[TB] FAIL sign_ffff: sinal=%b bcd=%h, required 1 00001", bus_if.sinal, bus_if.bcd);
    end
    strobe(16'h8000);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.sinal !== 1'b1 || bus_if.bcd !== 20'h32768 ||
        bus_if.seg !== {7'b0000110, 7'b0010010, 7'b0001111, 7'b0100000, 7'b0000000}) begin
      tests_failed++;
      $display("[TB] FAIL sign_8000: sinal=%b bcd=%h, required 1 32768", bus_if.sinal, bus_if.bcd);
    end
    strobe(16'd42);
    observe(20, -1, 16'd0, busy, npr, lastp, mid);
    tests_run++;
    if (bus_if.sinal !== 1'b0 || bus_if.bcd !== 20'h00042) begin
      tests_failed++;
      $display("[TB] FAIL sign_positive: sinal=%b bcd=%h, required 0 00042", bus_if.sinal, bus_if.bcd);
    end
`else
    tests_run++;
    if (bus_if.sinal !== 1'b0 || bus_if.bcd !== 20'h65535) begin
      tests_failed++;
      $display("[TB] FAIL unsigned_ffff: sinal=%b bcd=%h, required 0 65535", bus_if.sinal, bus_if.bcd);
    end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_value_12345();
    test_max_and_zero();
    test_request_while_busy();
    test_drop_in_atualiza();
    test_back_to_back();
    test_reset_mid();
    test_sign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
